// File: rtl/down_counter_timer_pkg.sv
// Shared types and helpers for the loadable countdown timer.
package down_counter_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoaded,
    StRun,
    StDone
  } state_e;

  // A single-cycle prescaler still needs a one-bit register to be legal.
  function automatic int unsigned presc_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/down_counter_timer_if.sv
// Load port and status outputs of the countdown timer.
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load_valid, load_value, start, stop,
    input  load_ready, count, busy, tc, done
  );

  modport slave (
    input  load_valid, load_value, start, stop,
    output load_ready, count, busy, tc, done
  );
endinterface

// File: rtl/down_counter_timer_tick_prescaler.sv
// Divides clk by PRESCALE; tick is high in the last cycle of each enabled period.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned CntW     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_end;

  assign at_end = (cnt_q == CntW'(PRESCALE - 1));
  assign tick_o = en_i && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable countdown timer with tc pulse and sticky done.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN to reload the last loaded value on terminal count.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_timer_if.slave  bus
);

  localparam int unsigned PsW = presc_width(PRESCALE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, busy_q, ready_q;
  logic             load_fire, tick, terminal;

  assign load_fire = bus.load_valid && ready_q;
  assign terminal  = tick && (count_q == WIDTH'(1));

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .CntW     (PsW)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q != StRun),
    .en_i    (state_q == StRun),
    .tick_o  (tick)
  );

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (load_fire) begin
      reload_q <= bus.load_value;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_fire) begin
          state_d = StLoaded;
          count_d = bus.load_value;
        end
      end
      StLoaded: begin
        if (load_fire) begin
          count_d = bus.load_value;
        end else if (bus.start && !bus.stop) begin
          if (count_q != '0) begin
            state_d = StRun;
          end else begin
            state_d = StDone;
            tc_d    = 1'b1;
          end
        end
      end
      StRun: begin
        // Terminal tick beats a concurrent stop; a plain stop beats an ordinary tick.
        if (terminal) begin
          tc_d    = 1'b1;
          count_d = '0;
          state_d = StDone;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = StRun;
          end
`endif
        end else if (bus.stop) begin
          state_d = StLoaded;
        end else if (tick) begin
          count_d = count_q - WIDTH'(1);
        end
      end
      StDone: begin
        count_d = '0;
        if (load_fire) begin
          state_d = StLoaded;
          count_d = bus.load_value;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= (state_d == StDone);
      busy_q  <= (state_d == StRun);
      ready_q <= (state_d != StRun);
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: WIDTH=4 with PRESCALE=1 and PRESCALE=3 instances.
module tb_down_counter_timer;

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       done;
    logic       busy;
    logic       ready;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  obs_t sb[$];
  obs_t ex;

  down_counter_timer_if #(.WIDTH(4)) bus1 ();
  down_counter_timer_if #(.WIDTH(4)) bus2 ();

  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t e(input int c, input bit tc, input bit done, input bit busy);
    logic [3:0] cv;
    cv = c[3:0];
    return '{count: cv, tc: tc, done: done, busy: busy, ready: !busy};
  endfunction

  function automatic obs_t obs1();
    return '{count: bus1.count, tc: bus1.tc, done: bus1.done, busy: bus1.busy,
             ready: bus1.load_ready};
  endfunction

  function automatic obs_t obs2();
    return '{count: bus2.count, tc: bus2.tc, done: bus2.done, busy: bus2.busy,
             ready: bus2.load_ready};
  endfunction

  // Advance one clock, sample point is 1ns after the edge; commands are single-cycle pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus1.load_valid = 1'b0;
    bus1.start      = 1'b0;
    bus1.stop       = 1'b0;
    bus2.load_valid = 1'b0;
    bus2.start      = 1'b0;
    bus2.stop       = 1'b0;
  endtask

  task automatic load1(input int v);
    bus1.load_valid = 1'b1;
    bus1.load_value = v[3:0];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus1.load_valid = 1'($urandom);
      bus1.load_value = 4'($urandom);
      bus1.start      = 1'($urandom);
      bus1.stop       = 1'($urandom);
      bus2.load_valid = 1'($urandom);
      bus2.load_value = 4'($urandom);
      bus2.start      = 1'($urandom);
      bus2.stop       = 1'($urandom);
      @(posedge clk);
      #1;
      ex = e(0, 0, 0, 0);
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL reset1[%0d]: got %h want %h", i, obs1(), ex);
      end
      checks++;
      if (obs2() !== ex) begin
        errors++;
        $display("FAIL reset3[%0d]: got %h want %h", i, obs2(), ex);
      end
    end
    bus1.load_valid = 1'b0; bus1.start = 1'b0; bus1.stop = 1'b0;
    bus2.load_valid = 1'b0; bus2.start = 1'b0; bus2.stop = 1'b0;
    rst = 1'b1;
    // Start in IDLE is ignored.
    bus1.start = 1'b1;
    sb.push_back(e(0, 0, 0, 0));
    while (sb.size() > 0) begin
      ex = sb.pop_front();
      cyc();
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL idle_start: got %h want %h", obs1(), ex);
      end
    end
  endtask

  task automatic test_countdown();
    load1(5);
    sb.push_back(e(5, 0, 0, 0));
    cyc();
    bus1.start = 1'b1;
    for (int v = 5; v >= 1; v--) sb.push_back(e(v, 0, 0, 1));
    sb.push_back(e(0, 1, 1, 0));
    sb.push_back(e(0, 0, 1, 0));
    // First entry belongs to the load cycle that already elapsed.
    ex = sb.pop_front();
    checks++;
    if (obs1() !== ex) begin
      errors++;
      $display("FAIL countdown_load: got %h want %h", obs1(), ex);
    end
    while (sb.size() > 0) begin
      ex = sb.pop_front();
      cyc();
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL countdown: got %h want %h", obs1(), ex);
      end
    end
  endtask

  task automatic test_pause_resume();
    load1(9);
    sb.push_back(e(9, 0, 0, 0));
    sb.push_back(e(9, 0, 0, 1));
    sb.push_back(e(8, 0, 0, 1));
    sb.push_back(e(7, 0, 0, 1));
    sb.push_back(e(6, 0, 0, 1));
    for (int k = 0; k < 5; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) bus1.start = 1'b1;
      if (k == 4) bus1.stop = 1'b1;
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL pause_run[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
    for (int k = 0; k < 5; k++) sb.push_back(e(6, 0, 0, 0));
    while (sb.size() > 0) begin
      ex = sb.pop_front();
      cyc();
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL pause_hold: got %h want %h", obs1(), ex);
      end
    end
    bus1.start = 1'b1;
    for (int v = 6; v >= 1; v--) sb.push_back(e(v, 0, 0, 1));
    sb.push_back(e(0, 1, 1, 0));
    sb.push_back(e(0, 0, 1, 0));
    while (sb.size() > 0) begin
      ex = sb.pop_front();
      cyc();
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL resume: got %h want %h", obs1(), ex);
      end
    end
  endtask

  task automatic test_load_zero();
    load1(0);
    sb.push_back(e(0, 0, 0, 0));
    sb.push_back(e(0, 1, 1, 0));
    sb.push_back(e(0, 0, 1, 0));
    for (int k = 0; k < 3; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) bus1.start = 1'b1;
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL load_zero[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
  endtask

  task automatic test_prescale3();
    int c;
    bus2.load_valid = 1'b1;
    bus2.load_value = 4'd15;
    sb.push_back(e(15, 0, 0, 0));
    // RUN entry at k=0, one decrement per 3 cycles, tc 45 cycles later.
    for (int k = 0; k < 45; k++) begin
      c = 15 - k / 3;
      sb.push_back(e(c, 0, 0, 1));
    end
    sb.push_back(e(0, 1, 1, 0));
    for (int k = 0; sb.size() > 0; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) bus2.start = 1'b1;
      checks++;
      if (obs2() !== ex) begin
        errors++;
        $display("FAIL prescale3[%0d]: got %h want %h", k, obs2(), ex);
      end
    end
  endtask

  task automatic test_load_in_run();
    load1(7);
    sb.push_back(e(7, 0, 0, 0));
    for (int v = 7; v >= 1; v--) sb.push_back(e(v, 0, 0, 1));
    sb.push_back(e(0, 1, 1, 0));
    for (int k = 0; sb.size() > 0; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) bus1.start = 1'b1;
      if (k == 2) load1(2);
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL load_in_run[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
  endtask

  task automatic test_simultaneous();
    // start+stop in LOADED, then load+start in LOADED.
    load1(4);
    sb.push_back(e(4, 0, 0, 0));
    sb.push_back(e(4, 0, 0, 0));
    sb.push_back(e(8, 0, 0, 0));
    sb.push_back(e(8, 0, 0, 0));
    for (int k = 0; sb.size() > 0; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) begin bus1.start = 1'b1; bus1.stop = 1'b1; end
      if (k == 1) begin load1(8); bus1.start = 1'b1; end
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL sim_loaded[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
    // stop on the terminal tick.
    load1(2);
    sb.push_back(e(2, 0, 0, 0));
    sb.push_back(e(2, 0, 0, 1));
    sb.push_back(e(1, 0, 0, 1));
    sb.push_back(e(0, 1, 1, 0));
    for (int k = 0; sb.size() > 0; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) bus1.start = 1'b1;
      if (k == 2) bus1.stop = 1'b1;
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL stop_terminal[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
    // reset mid-RUN at count 3.
    load1(5);
    sb.push_back(e(5, 0, 0, 0));
    sb.push_back(e(5, 0, 0, 1));
    sb.push_back(e(4, 0, 0, 1));
    sb.push_back(e(3, 0, 0, 1));
    sb.push_back(e(0, 0, 0, 0));
    sb.push_back(e(0, 0, 0, 0));
    for (int k = 0; sb.size() > 0; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0) bus1.start = 1'b1;
      if (k == 3) rst = 1'b0;
      if (k == 4) rst = 1'b1;
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL reset_mid_run[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
  endtask

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    load1(3);
    sb.push_back(e(3, 0, 0, 0));
    for (int r = 0; r < 3; r++) begin
      sb.push_back(r == 0 ? e(3, 0, 0, 1) : e(3, 1, 0, 1));
      sb.push_back(e(2, 0, 0, 1));
      sb.push_back(e(1, 0, 0, 1));
    end
    sb.push_back(e(3, 1, 0, 1));
    sb.push_back(e(3, 0, 0, 0));
    sb.push_back(e(0, 0, 0, 0));
    sb.push_back(e(0, 1, 1, 0));
    for (int k = 0; sb.size() > 0; k++) begin
      ex = sb.pop_front();
      cyc();
      if (k == 0 || k == 12) bus1.start = 1'b1;
      if (k == 10) bus1.stop = 1'b1;
      if (k == 11) load1(0);
      checks++;
      if (obs1() !== ex) begin
        errors++;
        $display("FAIL auto_reload[%0d]: got %h want %h", k, obs1(), ex);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus1.load_valid = 1'b0; bus1.load_value = '0; bus1.start = 1'b0; bus1.stop = 1'b0;
    bus2.load_valid = 1'b0; bus2.load_value = '0; bus2.start = 1'b0; bus2.stop = 1'b0;
    test_reset();
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_countdown();
    test_pause_resume();
    test_load_zero();
    test_prescale3();
    test_load_in_run();
    test_simultaneous();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
